// File: rtl/axi_ram_slave.sv
// AXI3-style memory responder standing in for external memory in simulation.
// Independent single-outstanding read and write engines over a word-wide RAM with byte strobes.
module axi_ram_slave #(
  parameter int unsigned ADDR_W    = 12,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W-1:0] idx_t;

  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  // Upper address bits alias, size is always 4 bytes, wid is not checked.
  logic unused_bits;
  assign unused_bits = ^{wid, awaddr[31:ADDR_W+2], awaddr[1:0], araddr[31:ADDR_W+2], araddr[1:0]};

  function automatic idx_t next_idx(idx_t idx, logic [3:0] len, logic [1:0] burst);
    idx_t mask;
    idx_t res;
    mask = idx_t'(len);
    res  = idx + idx_t'(1);
    if (burst == 2'b00) begin
      res = idx;
    end else if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      res = (idx & ~mask) | ((idx + idx_t'(1)) & mask);
    end
    return res;
  endfunction

  // ---------------- read engine ----------------
  typedef enum logic {RIdle, RBurst} r_state_e;
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_id_q, r_len_q, r_cnt_q;
  logic [1:0]  r_burst_q;
  logic        r_err_q, rlast_q;
  idx_t        r_idx_q, r_nidx;
  logic [31:0] rdata_q;

  always_comb begin
    r_state_d = r_state_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        arready = 1'b1;
        if (arvalid) r_state_d = RBurst;
      end
      RBurst: begin
        rvalid = 1'b1;
        if (rready && rlast_q) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign r_nidx = next_idx(r_idx_q, r_len_q, r_burst_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rlast_q   <= 1'b0;
      r_idx_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (arvalid && arready) begin
        r_id_q    <= arid;
        r_len_q   <= arlen;
        r_cnt_q   <= '0;
        r_burst_q <= arburst;
        r_err_q   <= (arsize != 3'b010);
        r_idx_q   <= araddr[ADDR_W+1:2];
        rdata_q   <= mem[araddr[ADDR_W+1:2]];
        rlast_q   <= (arlen == 4'd0);
      end else if (rvalid && rready) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          // Sampling mem here returns pre-write data on a same-cycle collision.
          r_idx_q <= r_nidx;
          r_cnt_q <= r_cnt_q + 4'd1;
          rdata_q <= mem[r_nidx];
          rlast_q <= ((r_cnt_q + 4'd1) == r_len_q);
        end
      end
    end
  end

  assign rid   = r_id_q;
  assign rdata = rdata_q;
  assign rresp = r_err_q ? 2'b10 : 2'b00;
  assign rlast = rlast_q;

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  w_state_e   w_state_q, w_state_d;
  logic [3:0] w_id_q, w_len_q, w_cnt_q;
  logic [1:0] w_burst_q;
  logic       w_err_q, w_end, w_cnt_last;
  idx_t       w_idx_q;

  assign w_cnt_last = (w_cnt_q == w_len_q);
  assign w_end      = wlast || w_cnt_last;

  always_comb begin
    w_state_d = w_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready = 1'b1;
        if (awvalid) w_state_d = WData;
      end
      WData: begin
        wready = 1'b1;
        if (wvalid && w_end) w_state_d = WResp;
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_idx_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (awvalid && awready) begin
        w_id_q    <= awid;
        w_len_q   <= awlen;
        w_cnt_q   <= '0;
        w_burst_q <= awburst;
        w_err_q   <= (awsize != 3'b010);
        w_idx_q   <= awaddr[ADDR_W+1:2];
      end else if (wvalid && wready) begin
        w_idx_q <= next_idx(w_idx_q, w_len_q, w_burst_q);
        w_cnt_q <= w_cnt_q + 4'd1;
        if (w_end && (wlast != w_cnt_last)) w_err_q <= 1'b1;
      end
    end
  end

  // wready is low whenever reset is asserted, so no writes slip through mid-burst.
  always_ff @(posedge aclk) begin
    if (wvalid && wready) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bid   = w_id_q;
  assign bresp = (bvalid && w_err_q) ? 2'b10 : 2'b00;

endmodule
